// File: rtl/fft_stream_engine.sv
// fft_stream_engine: streaming N-point complex radix-2 DIT FFT (N = 4 or 8)
// built around one shared butterfly. Samples are written to bit-reversed
// addresses as they arrive, LOG2_N*N/2 in-place butterflies run one per
// cycle, and bins leave in natural order.
// Build option: FFT_STAGE_SCALE_EN halves every butterfly output (result is
// DFT/N); without it butterfly outputs saturate to WIDTH bits.
//
// state   | meaning
// LOAD    | accept N samples, store at bit-reversed addresses
// COMPUTE | one butterfly per cycle, all stages in place
// UNLOAD  | present bins 0..N-1 over the output handshake
module fft_stream_engine #(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_last,
  output logic             busy
);

  localparam int N  = 1 << LOG2_N;
  localparam int AW = LOG2_N;
  localparam int JW = LOG2_N - 1;
  localparam int SW = 2;
  localparam int EW = WIDTH + 2;
  localparam int PW = WIDTH + 17;

  if (LOG2_N != 2 && LOG2_N != 3) begin : g_bad_size
    $error("fft_stream_engine: LOG2_N must be 2 or 3");
  end

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] stage;
  logic [JW-1:0] bfly;
  logic signed [WIDTH-1:0] mem_re [N];
  logic signed [WIDTH-1:0] mem_im [N];

  logic in_fire, out_fire, last_in, last_bfly;
  logic [AW-1:0] span, k_idx, addr_a, addr_b;
  logic [1:0] tw_idx;
  logic signed [15:0] w_re, w_im;
  logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] bre_x, bim_x, wre_x, wim_x, acc_re, acc_im;
  logic signed [EW-1:0] t_re, t_im, p_re, p_im, q_re, q_im;
  logic signed [WIDTH-1:0] p_re_w, p_im_w, q_re_w, q_im_w;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Reduce a WIDTH+2 bit butterfly result back to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] post(input logic signed [EW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
    return WIDTH'(v >>> 1);
`else
    localparam logic signed [EW-1:0] SAT_HI = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {3'b111, {(WIDTH-1){1'b0}}};
    if (v > SAT_HI) return WIDTH'(SAT_HI);
    else if (v < SAT_LO) return WIDTH'(SAT_LO);
    else return WIDTH'(v);
`endif
  endfunction

  assign last_in   = (wr_ptr == AW'(N - 1));
  assign last_bfly = (stage == SW'(LOG2_N - 1)) && (bfly == JW'(N / 2 - 1));
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Butterfly addressing: span = 2^stage, a = group base + k, b = a + span.
  // Twiddle index is expressed in 8-point table steps so N=4 uses 0 and 2.
  always_comb begin
    span   = AW'(1) << stage;
    k_idx  = AW'(bfly) & (span - AW'(1));
    addr_a = ((AW'(bfly) >> stage) << (stage + SW'(1))) | k_idx;
    addr_b = addr_a + span;
    tw_idx = 2'(k_idx << (SW'(2) - stage));
  end

  // Q1.15 twiddle table, exp(-i*2*pi*m/8) for m = 0..3.
  always_comb begin
    w_re = 16'sd32767;
    w_im = 16'sd0;
    case (tw_idx)
      2'd1: begin w_re = 16'sd23170;  w_im = -16'sd23170; end
      2'd2: begin w_re = 16'sd0;      w_im = -16'sd32767; end
      2'd3: begin w_re = -16'sd23170; w_im = -16'sd23170; end
      default: ;
    endcase
  end

  // Shared butterfly: t = B*W rounded (bypassed for W0), P = A+t, Q = A-t.
  always_comb begin
    a_re   = mem_re[addr_a];
    a_im   = mem_im[addr_a];
    b_re   = mem_re[addr_b];
    b_im   = mem_im[addr_b];
    bre_x  = PW'(b_re);
    bim_x  = PW'(b_im);
    wre_x  = PW'(w_re);
    wim_x  = PW'(w_im);
    acc_re = bre_x * wre_x - bim_x * wim_x + PW'(16384);
    acc_im = bre_x * wim_x + bim_x * wre_x + PW'(16384);
    if (tw_idx == 2'd0) begin
      t_re = EW'(b_re);
      t_im = EW'(b_im);
    end else begin
      t_re = EW'(acc_re >>> 15);
      t_im = EW'(acc_im >>> 15);
    end
    p_re   = EW'(a_re) + t_re;
    p_im   = EW'(a_im) + t_im;
    q_re   = EW'(a_re) - t_re;
    q_im   = EW'(a_im) - t_im;
    p_re_w = post(p_re);
    p_im_w = post(p_im);
    q_re_w = post(q_re);
    q_im_w = post(q_im);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_re    = '0;
    out_im    = '0;
    case (state)
      LOAD: begin
        // Held low while reset is asserted even though the state is LOAD.
        in_ready = ~rst;
        if (in_valid && in_ready && last_in) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_bfly) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_re    = mem_re[rd_ptr];
        out_im    = mem_im[rd_ptr];
        out_last  = (rd_ptr == AW'(N - 1));
        if (out_ready && out_last) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Pointers, butterfly sequencing and sample storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      stage  <= '0;
      bfly   <= '0;
      for (int i = 0; i < N; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            mem_re[bitrev(wr_ptr)] <= in_re;
            mem_im[bitrev(wr_ptr)] <= in_im;
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        COMPUTE: begin
          mem_re[addr_a] <= p_re_w;
          mem_im[addr_a] <= p_im_w;
          mem_re[addr_b] <= q_re_w;
          mem_im[addr_b] <= q_im_w;
          if (bfly == JW'(N / 2 - 1)) begin
            bfly  <= '0;
            stage <= last_bfly ? '0 : stage + SW'(1);
          end else begin
            bfly <= bfly + JW'(1);
          end
        end
        UNLOAD: begin
          if (out_fire) rd_ptr <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_engine.sv
// Testbench for fft_stream_engine: one N=4 and one N=8 instance, directed
// and random frames checked against an integer FFT reference model.
`timescale 1ns/1ps
module tb_fft_stream_engine;

  localparam int W = 16;
`ifdef FFT_STAGE_SCALE_EN
  localparam bit SCALED = 1'b1;
`else
  localparam bit SCALED = 1'b0;
`endif
  localparam int IMP4   = SCALED ? 250 : 1000;
  localparam int IMP8   = SCALED ? 125 : 1000;
  localparam int ALT_X2 = SCALED ? 400 : 1600;
  localparam int SAT_X0 = SCALED ? 20000 : 32767;

  localparam longint TWR [4] = '{32767, 23170, 0, -23170};
  localparam longint TWI [4] = '{0, -23170, -32767, -23170};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic in_valid_d = 1'b0, out_ready_d = 1'b0, sel8 = 1'b0;
  logic [W-1:0] in_re_d = '0, in_im_d = '0;

  logic in_ready4, out_valid4, out_last4, busy4;
  logic in_ready8, out_valid8, out_last8, busy8;
  logic [W-1:0] out_re4, out_im4, out_re8, out_im8;

  fft_stream_engine #(.WIDTH(W), .LOG2_N(2)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_d & ~sel8), .in_ready(in_ready4),
    .in_re(in_re_d), .in_im(in_im_d),
    .out_valid(out_valid4), .out_ready(out_ready_d),
    .out_re(out_re4), .out_im(out_im4),
    .out_last(out_last4), .busy(busy4)
  );

  fft_stream_engine #(.WIDTH(W), .LOG2_N(3)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_d & sel8), .in_ready(in_ready8),
    .in_re(in_re_d), .in_im(in_im_d),
    .out_valid(out_valid8), .out_ready(out_ready_d),
    .out_re(out_re8), .out_im(out_im8),
    .out_last(out_last8), .busy(busy8)
  );

  logic o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [W-1:0] o_out_re, o_out_im;
  assign o_in_ready  = sel8 ? in_ready8  : in_ready4;
  assign o_out_valid = sel8 ? out_valid8 : out_valid4;
  assign o_out_last  = sel8 ? out_last8  : out_last4;
  assign o_busy      = sel8 ? busy8      : busy4;
  assign o_out_re    = sel8 ? out_re8    : out_re4;
  assign o_out_im    = sel8 ? out_im8    : out_im4;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int fr_re [8], fr_im [8];
  int ex_re [8], ex_im [8];
  int got_re [8], got_im [8];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int k, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) if ((k & (1 << i)) != 0) r |= 1 << (lg - 1 - i);
    return r;
  endfunction

  // Butterfly output reduction back to 16 bits.
  function automatic longint fin(input longint v);
    longint h;
    if (SCALED) begin
      h = (v >>> 1) & 64'hFFFF;
      if (h >= 32768) h -= 65536;
      return h;
    end
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: textbook in-place radix-2 DIT over groups of 2*span.
  task automatic model(input int n, input int lg);
    longint xr [8], xi [8];
    for (int k = 0; k < n; k++) begin
      xr[brev(k, lg)] = fr_re[k];
      xi[brev(k, lg)] = fr_im[k];
    end
    for (int s = 0; s < lg; s++) begin
      int span = 1 << s;
      for (int g = 0; g < n; g += 2 * span) begin
        for (int k = 0; k < span; k++) begin
          int ia = g + k;
          int ib = g + k + span;
          int m  = k * (n / (2 * span)) * (8 / n);
          longint tr, ti, ar, ai;
          ar = xr[ia];
          ai = xi[ia];
          if (m == 0) begin
            tr = xr[ib];
            ti = xi[ib];
          end else begin
            tr = (xr[ib] * TWR[m] - xi[ib] * TWI[m] + 16384) >>> 15;
            ti = (xr[ib] * TWI[m] + xi[ib] * TWR[m] + 16384) >>> 15;
          end
          xr[ia] = fin(ar + tr);
          xi[ia] = fin(ai + ti);
          xr[ib] = fin(ar - tr);
          xi[ib] = fin(ai - ti);
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      ex_re[k] = int'(xr[k]);
      ex_im[k] = int'(xi[k]);
    end
  endtask

  task automatic fill_const(input int v0, input int v1, input int v2, input int v3);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
    fr_re[0] = v0; fr_re[1] = v1; fr_re[2] = v2; fr_re[3] = v3;
  endtask

  task automatic fill_random();
    logic [15:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 16'($urandom);
      fr_re[k] = int'($signed(r));
      r = 16'($urandom);
      fr_im[k] = int'($signed(r));
    end
  endtask

  // Returns at the negedge following the last input handshake.
  task automatic send_frame(input int n);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      @(negedge clk);
      in_valid_d = 1'b1;
      in_re_d = 16'(fr_re[k]);
      in_im_d = 16'(fr_im[k]);
      while (o_in_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk("send_in_ready", o_in_ready, 1);
    end
    @(negedge clk);
    in_valid_d = 1'b0;
  endtask

  // Counts cycles from the last input handshake to out_valid while offering
  // junk input that must be ignored.
  task automatic wait_out(input int c, input string tag);
    int cyc = 0;
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_in_ready_cmp"}, o_in_ready, 0);
    in_valid_d = 1'b1;
    while (o_out_valid !== 1'b1 && cyc < 100) begin
      in_re_d = 16'($urandom);
      in_im_d = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid_d = 1'b0;
    chk({tag, "_latency"}, cyc, c);
  endtask

  task automatic recv_frame(input int n, input int stall_bin, input string tag);
    for (int b = 0; b < n; b++) begin
      if (b == stall_bin) begin
        out_ready_d = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk({tag, "_bp_valid"}, o_out_valid, 1);
          chk({tag, "_bp_re"}, $signed(o_out_re), ex_re[b]);
          chk({tag, "_bp_im"}, $signed(o_out_im), ex_im[b]);
          chk({tag, "_bp_in_ready"}, o_in_ready, 0);
        end
      end
      out_ready_d = 1'b1;
      chk({tag, "_valid"}, o_out_valid, 1);
      chk({tag, "_re"}, $signed(o_out_re), ex_re[b]);
      chk({tag, "_im"}, $signed(o_out_im), ex_im[b]);
      chk({tag, "_last"}, o_out_last, (b == n - 1));
      chk({tag, "_busy_unload"}, o_busy, 0);
      got_re[b] = int'($signed(o_out_re));
      got_im[b] = int'($signed(o_out_im));
      @(negedge clk);
    end
    out_ready_d = 1'b0;
    chk({tag, "_in_ready_after"}, o_in_ready, 1);
    chk({tag, "_valid_after"}, o_out_valid, 0);
  endtask

  task automatic run_frame(input bit use8, input int stall_bin, input string tag);
    int n;
    int lg;
    n  = use8 ? 8 : 4;
    lg = use8 ? 3 : 2;
    sel8 = use8;
    model(n, lg);
    send_frame(n);
    wait_out(lg * n / 2, tag);
    recv_frame(n, stall_bin, tag);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #12;
    sel8 = 1'b0;
    #1;
    chk("rst_in_ready4", o_in_ready, 0);
    chk("rst_out_valid4", o_out_valid, 0);
    chk("rst_busy4", o_busy, 0);
    chk("rst_out_re4", $signed(o_out_re), 0);
    chk("rst_out_last4", o_out_last, 0);
    sel8 = 1'b1;
    #1;
    chk("rst_in_ready8", o_in_ready, 0);
    chk("rst_out_valid8", o_out_valid, 0);
    sel8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready4", in_ready4, 1);
    chk("post_rst_in_ready8", in_ready8, 1);

    fill_const(1000, 0, 0, 0);
    run_frame(1'b0, -1, "imp4");
    for (int b = 0; b < 4; b++) chk("imp4_const", got_re[b], IMP4);

    fill_const(1000, 0, 0, 0);
    run_frame(1'b1, -1, "imp8");
    for (int b = 0; b < 8; b++) chk("imp8_const", got_re[b], IMP8);

    fill_const(400, -400, 400, -400);
    run_frame(1'b0, -1, "alt4");
    chk("alt4_x2", got_re[2], ALT_X2);
    chk("alt4_x0", got_re[0], 0);

    fill_const(20000, 20000, 20000, 20000);
    run_frame(1'b0, -1, "sat4");
    chk("sat4_x0", got_re[0], SAT_X0);
    chk("sat4_x1", got_re[1], 0);

    fill_random();
    run_frame(1'b0, 1, "bp4");

    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame(f[0], (f == 3) ? 5 : -1, "rnd");
    end

    // Reset two cycles into COMPUTE, then a clean impulse frame.
    sel8 = 1'b0;
    fill_const(777, 0, 0, 0);
    send_frame(4);
    chk("mid_busy_before", o_busy, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_valid", o_out_valid, 0);
    chk("mid_rst_in_ready", o_in_ready, 0);
    chk("mid_rst_re", $signed(o_out_re), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("mid_no_stale", o_out_valid, 0);
    end
    chk("mid_in_ready", o_in_ready, 1);
    fill_const(1000, 0, 0, 0);
    run_frame(1'b0, -1, "mid_imp4");
    for (int b = 0; b < 4; b++) chk("mid_imp4_const", got_re[b], IMP4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
